piece_motion_ctrl: RTL and testbench

- Upstream stage of a per-piece sprite renderer. One instance per piece.
- Holds the piece's board square, its capture state and its selection state.
- Animates square-to-square moves one frame at a time.
- Drives the renderer's offsetX/offsetY (board-relative pixels; the renderer adds the 80 px board margin), captured and selected inputs.

---
 rtl/piece_motion_ctrl.sv | 131 +++++++++++++
 tb/tb_piece_motion_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/piece_motion_ctrl.sv
// Per-piece board position, capture and selection state with frame-paced move animation.
// Define PIECE_MOTION_SNAP_EN to jump straight to the target on the first frame_tick.
module piece_motion_ctrl #(
  parameter int SQUARE_PX = 60,
  parameter int STEP_PX   = 4,
  parameter int INIT_COL  = 0,
  parameter int INIT_ROW  = 0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] dst_col,
  input  logic [2:0] dst_row,
  input  logic       capture_in,
  input  logic       sel_set,
  input  logic       sel_clr,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       captured,
  output logic       selected,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] SQ     = 10'(SQUARE_PX);
  localparam logic [9:0] INIT_X = 10'(INIT_COL * SQUARE_PX);
  localparam logic [9:0] INIT_Y = 10'(INIT_ROW * SQUARE_PX);

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_e;

  state_e     state_q, state_d;
  logic [9:0] offx_q, offx_d, offy_q, offy_d;
  logic [9:0] tgtx_q, tgtx_d, tgty_q, tgty_d;
  logic       captured_q, captured_d, selected_q, selected_d;
  logic [9:0] nx, ny;
  logic       accept;

`ifndef PIECE_MOTION_SNAP_EN
  localparam logic signed [10:0] STEP_S = 11'(STEP_PX);
  localparam logic [9:0]         STEP_U = 10'(STEP_PX);

  // Clamp the final step to the remaining distance so an axis never overshoots.
  function automatic logic [9:0] step_axis(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       step_axis = cur + STEP_U;
    else if (diff < -STEP_S) step_axis = cur - STEP_U;
    else                     step_axis = tgt;
  endfunction
`endif

  always_comb begin
`ifdef PIECE_MOTION_SNAP_EN
    nx = tgtx_q;
    ny = tgty_q;
`else
    nx = step_axis(offx_q, tgtx_q);
    ny = step_axis(offy_q, tgty_q);
`endif
    state_d    = state_q;
    offx_d     = offx_q;
    offy_d     = offy_q;
    tgtx_d     = tgtx_q;
    tgty_d     = tgty_q;
    accept     = 1'b0;
    move_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    captured_d = captured_q | capture_in;

    case (state_q)
      IDLE: begin
        move_ready = !captured_q;
        if (move_valid && !captured_q) begin
          accept  = 1'b1;
          tgtx_d  = {7'd0, dst_col} * SQ;
          tgty_d  = {7'd0, dst_row} * SQ;
          state_d = MOVE;
        end
      end
      MOVE: begin
        busy = 1'b1;
        if (frame_tick) begin
          offx_d = nx;
          offy_d = ny;
          if (nx == tgtx_q && ny == tgty_q) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clearing sources outrank sel_set.
    selected_d = selected_q;
    if (sel_set && !captured_q) selected_d = 1'b1;
    if (sel_clr || capture_in || accept) selected_d = 1'b0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      offx_q     <= INIT_X;
      offy_q     <= INIT_Y;
      captured_q <= 1'b0;
      selected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offx_q     <= offx_d;
      offy_q     <= offy_d;
      captured_q <= captured_d;
      selected_q <= selected_d;
    end
  end

  // Targets are only consulted in MOVE, which is always entered through a fresh latch.
  always_ff @(posedge vga_clk) begin
    tgtx_q <= tgtx_d;
    tgty_q <= tgty_d;
  end

  assign offsetX  = offx_q;
  assign offsetY  = offy_q;
  assign captured = captured_q;
  assign selected = selected_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Scoreboard bench for piece_motion_ctrl: a square/step reference model predicts every cycle's outputs.
module tb_piece_motion_ctrl;

  localparam int SQ   = 60;
  localparam int STEP = 7;
  localparam int IC   = 4;
  localparam int IR   = 7;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, move_valid = 1'b0;
  logic       move_ready;
  logic [2:0] dst_col = 3'd0, dst_row = 3'd0;
  logic       capture_in = 1'b0, sel_set = 1'b0, sel_clr = 1'b0;
  logic [9:0] offsetX, offsetY;
  logic       captured, selected, busy, done;

  piece_motion_ctrl #(
    .SQUARE_PX(SQ), .STEP_PX(STEP), .INIT_COL(IC), .INIT_ROW(IR)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick),
    .move_valid(move_valid), .move_ready(move_ready),
    .dst_col(dst_col), .dst_row(dst_row), .capture_in(capture_in),
    .sel_set(sel_set), .sel_clr(sel_clr), .offsetX(offsetX), .offsetY(offsetY),
    .captured(captured), .selected(selected), .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x; int y; bit cap; bit sel; bit busy; bit done; bit ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   model_dones = 0, seen_dones = 0;

  int mx, my, tx, ty;
  bit mcap, msel, mmoving, mdone;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int approach(input int c, input int t);
`ifdef PIECE_MOTION_SNAP_EN
    return (c == t) ? c : t;
`else
    if (t > c) return c + (((t - c) < STEP) ? (t - c) : STEP);
    else       return c - (((c - t) < STEP) ? (c - t) : STEP);
`endif
  endfunction

  task automatic model_step(input bit rst, input bit tick, input bit mv, input int dc, input int dr,
                            input bit capin, input bit ss, input bit sc);
    bit rdy, acc;
    if (rst) begin
      mx = IC * SQ; my = IR * SQ;
      mcap = 0; msel = 0; mmoving = 0; mdone = 0;
    end else begin
      rdy = !mmoving && !mdone && !mcap;
      acc = mv && rdy;
      if (ss && !mcap) msel = 1;
      if (sc || capin || acc) msel = 0;
      mcap = mcap || capin;
      if (mdone) mdone = 0;
      else if (mmoving) begin
        if (tick) begin
          mx = approach(mx, tx);
          my = approach(my, ty);
          if (mx == tx && my == ty) begin
            mmoving = 0; mdone = 1; model_dones++;
          end
        end
      end else if (acc) begin
        tx = dc * SQ; ty = dr * SQ; mmoving = 1;
      end
    end
    exp_q.push_back('{x: mx, y: my, cap: mcap, sel: msel, busy: mmoving, done: mdone,
                      ready: !mmoving && !mdone && !mcap});
  endtask

  task automatic cyc(input bit rst, input bit tick, input bit mv, input int dc, input int dr,
                     input bit capin, input bit ss, input bit sc);
    reset = rst; frame_tick = tick; move_valid = mv;
    dst_col = 3'(dc); dst_row = 3'(dr);
    capture_in = capin; sel_set = ss; sel_clr = sc;
    @(posedge vga_clk);
    #1;
    model_step(rst, tick, mv, dc, dr, capin, ss, sc);
  endtask

  // Alternating idle/tick cycles; optionally keeps requesting a different move while busy.
  task automatic run_ticks(input int n, input bit nag);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, nag, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  always @(negedge vga_clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("offsetX", int'(offsetX), mon_e.x);
      chk("offsetY", int'(offsetY), mon_e.y);
      chk("captured", int'(captured), int'(mon_e.cap));
      chk("selected", int'(selected), int'(mon_e.sel));
      chk("busy", int'(busy), int'(mon_e.busy));
      chk("done", int'(done), int'(mon_e.done));
      chk("move_ready", int'(move_ready), int'(mon_e.ready));
      if (done) seen_dones++;
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // Acceptance coinciding with a tick, then a one-square move with a nagging second request.
    cyc(0, 1, 1, 5, 7, 0, 1, 0);
    run_ticks(12, 1);
    cyc(0, 0, 1, 4, 7, 0, 0, 0);
    run_ticks(12, 0);
    // Diagonal slide to the corner.
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    run_ticks(65, 0);
    // Zero-distance move.
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    run_ticks(3, 0);
    // Select, move, clear-wins, capture mid-move.
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    run_ticks(40, 1);
    cyc(0, 0, 1, 3, 3, 0, 1, 0);
    run_ticks(3, 0);
    // Reset during an active move.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 7, 0, 0, 0);
    run_ticks(5, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    run_ticks(3, 0);
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge vga_clk);
    #1;
    chk("done_count", seen_dones, model_dones);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
